// File: rtl/memory_access_unit.sv
// Memory pipeline stage: launches word load/store transactions on a req/ack bus,
// stalls upstream while a transaction is outstanding, and registers the writeback values.
module memory_access_unit #(
  parameter logic [3:0]  LOAD_OPCODE    = 4'hA,
  parameter logic [3:0]  STORE_OPCODE   = 4'hB,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] result_i,
  input  logic [31:0] store_value_i,
  input  logic [31:0] memory_access_address_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic [31:0] instruction_o,
  output logic [31:0] result_o,
  output logic [31:0] pc_o,
  output logic        bus_error_o,
  output logic        align_error_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   count_r;
  logic [31:0]        hold_result_r;

  logic               mem_op_s;
  logic               aligned_s;
  logic               launch_s;
  logic               timeout_s;
  logic               busy_raw_s;
  logic               busy_s;

  // Decode of the presented instruction and the stall request to upstream.
  always_comb begin
    mem_op_s   = (instruction_i[31:28] == LOAD_OPCODE) || (instruction_i[31:28] == STORE_OPCODE);
    aligned_s  = (memory_access_address_i[1:0] == 2'b00);
    launch_s   = mem_op_s & aligned_s & ~flush_i & ~stall_i;
    timeout_s  = ~dmem_ack_i & (count_r == CNT_W'(TIMEOUT_CYCLES - 1));
    // The abandon cycle releases upstream so the dropped instruction is not relaunched.
    case (state_r)
      IDLE:    busy_raw_s = launch_s;
      ACCESS:  busy_raw_s = ~dmem_ack_i & ~timeout_s;
      HOLD:    busy_raw_s = stall_i;
      default: busy_raw_s = 1'b0;
    endcase
    busy_s = reset_n_i & busy_raw_s;
  end

  assign stall_o = stall_i | busy_s;

  // Transaction sequencing and all registered outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= IDLE;
      count_r       <= '0;
      hold_result_r <= 32'h0;
      dmem_req_o    <= 1'b0;
      dmem_we_o     <= 1'b0;
      dmem_addr_o   <= 32'h0;
      dmem_wdata_o  <= 32'h0;
      instruction_o <= 32'h0;
      result_o      <= 32'h0;
      pc_o          <= 32'h0;
      bus_error_o   <= 1'b0;
      align_error_o <= 1'b0;
    end else begin
      bus_error_o   <= 1'b0;
      align_error_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (stall_i) begin
            state_r <= IDLE;
          end else if (!mem_op_s || flush_i) begin
            instruction_o <= flush_i ? 32'h0 : instruction_i;
            result_o      <= result_i;
            pc_o          <= pc_i;
          end else if (!aligned_s) begin
            align_error_o <= 1'b1;
            instruction_o <= 32'h0;
            result_o      <= result_i;
            pc_o          <= pc_i;
          end else begin
            state_r      <= ACCESS;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= (instruction_i[31:28] == STORE_OPCODE);
            dmem_addr_o  <= memory_access_address_i;
            dmem_wdata_o <= store_value_i;
            count_r      <= '0;
          end
        end
        ACCESS: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            if (!stall_i) begin
              instruction_o <= instruction_i;
              result_o      <= dmem_we_o ? result_i : dmem_rdata_i;
              pc_o          <= pc_i;
              state_r       <= IDLE;
            end else begin
              hold_result_r <= dmem_we_o ? result_i : dmem_rdata_i;
              state_r       <= HOLD;
            end
          end else if (timeout_s) begin
            dmem_req_o    <= 1'b0;
            bus_error_o   <= 1'b1;
            instruction_o <= 32'h0;
            state_r       <= IDLE;
          end else begin
            count_r <= count_r + 1'b1;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            instruction_o <= instruction_i;
            result_o      <= hold_result_r;
            pc_o          <= pc_i;
            state_r       <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r    <= IDLE;
          dmem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
